// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline sequencing controller for the 5-stage MIPS core.
//
// A shadow copy of {valid, dest reg, RegWrite, MemRead} is kept for the
// instructions in EX, MEM and WB. From it the block works out four things:
//   - load-use stalls, which hold PC and IF/ID and bubble ID/EX;
//   - branch flushes, taken in MEM, which clear IF/ID, ID/EX and EX/MEM;
//   - registered ALU operand forwarding selects, valid for the whole EX cycle;
//   - saturating stall and flush event counters for performance debug.
//
// Ports
//   Clk, Rst_n          clock (rising edge), asynchronous active-low reset
//   ID_Valid            IF/ID holds a real instruction
//   ID_Rs, ID_Rt        source registers of the instruction in ID
//   ID_UsesRs/Rt        the instruction in ID actually reads that source
//   ID_WR               destination of the ID instruction (after RegDst)
//   ID_RegWrite         ID instruction writes the register file
//   ID_MemRead          ID instruction is a load
//   PCSrc               branch taken (resolved in MEM)
//   PC_Write            PC update enable
//   IFID_Write          IF/ID write enable
//   Flush_IFID          clear IF/ID
//   Flush_IDEX          bubble into ID/EX
//   Flush_EXMEM         bubble into EX/MEM
//   FwdA, FwdB          operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   StallCnt, FlushCnt  saturating event counters, CNT_W bits wide
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             ID_Valid,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic [4:0]       ID_WR,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             PCSrc,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             Flush_IFID,
    output logic             Flush_IDEX,
    output logic             Flush_EXMEM,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    // One shadow scoreboard entry. A bubble is the all-zero entry.
    typedef struct packed {
        logic       vld;
        logic [4:0] wr;
        logic       rw;
        logic       mr;
    } shadow_t;

    localparam shadow_t BUBBLE = '0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b10;
    localparam logic [1:0] FWD_MEM = 2'b01;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    shadow_t          r_s_ex;
    shadow_t          r_s_mem;
    shadow_t          r_s_wb;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // An entry produces register r only if it is live and writes the file.
    // Register $0 is hardwired to zero, so it never counts as produced.
    function automatic logic entry_match(input shadow_t e, input logic [4:0] r);
        return e.vld & e.rw & (e.wr == r) & (r != 5'd0);
    endfunction

    // The newest producer wins: EX (about to enter MEM) beats MEM.
    function automatic logic [1:0] fwd_sel(input logic uses,
                                           input logic hit_ex,
                                           input logic hit_mem);
        logic [1:0] sel;
        sel = FWD_RF;
        if (uses) begin
            if (hit_ex) begin
                sel = FWD_EX;
            end else if (hit_mem) begin
                sel = FWD_MEM;
            end
        end
        return sel;
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        res = v;
        if (v != {CNT_W{1'b1}}) begin
            res = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Hazard detection (combinational)
    // -----------------------------------------------------------------------
    logic    w_ex_hit_rs;
    logic    w_ex_hit_rt;
    logic    w_mem_hit_rs;
    logic    w_mem_hit_rt;
    logic    w_load_use;
    logic    w_stall;
    shadow_t w_s_id;
    logic [1:0] w_fwd_a_nxt;
    logic [1:0] w_fwd_b_nxt;

    assign w_ex_hit_rs  = entry_match(r_s_ex,  ID_Rs);
    assign w_ex_hit_rt  = entry_match(r_s_ex,  ID_Rt);
    assign w_mem_hit_rs = entry_match(r_s_mem, ID_Rs);
    assign w_mem_hit_rt = entry_match(r_s_mem, ID_Rt);

    // A load in EX whose result the ID instruction needs cannot be
    // forwarded in time; the ID instruction waits one cycle and then picks
    // the value up from MEM/WB.
    assign w_load_use = ID_Valid & r_s_ex.vld & r_s_ex.mr &
                        ((ID_UsesRs & w_ex_hit_rs) | (ID_UsesRt & w_ex_hit_rt));

    // A taken branch kills the ID instruction anyway, so it overrides the stall.
    assign w_stall = w_load_use & ~PCSrc;

    // Control bits of an invalid ID slot are forced low so it enters EX as
    // a harmless entry.
    always_comb begin
        w_s_id     = BUBBLE;
        w_s_id.vld = ID_Valid;
        w_s_id.wr  = ID_WR;
        w_s_id.rw  = ID_RegWrite & ID_Valid;
        w_s_id.mr  = ID_MemRead & ID_Valid;
    end

    assign w_fwd_a_nxt = fwd_sel(ID_UsesRs, w_ex_hit_rs, w_mem_hit_rs);
    assign w_fwd_b_nxt = fwd_sel(ID_UsesRt, w_ex_hit_rt, w_mem_hit_rt);

    // -----------------------------------------------------------------------
    // Shadow scoreboard: EX -> MEM -> WB
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_s_ex  <= BUBBLE;
            r_s_mem <= BUBBLE;
            r_s_wb  <= BUBBLE;
        end else begin
            r_s_wb <= r_s_mem;
            if (PCSrc) begin
                // Branch in MEM: everything younger than it is squashed.
                r_s_mem <= BUBBLE;
                r_s_ex  <= BUBBLE;
            end else if (w_stall) begin
                r_s_mem <= r_s_ex;
                r_s_ex  <= BUBBLE;
            end else begin
                r_s_mem <= r_s_ex;
                r_s_ex  <= w_s_id;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Forwarding selects, registered as the ID instruction enters EX
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (PCSrc || w_stall) begin
            // A bubble enters EX; it reads nothing.
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_fwd_a <= w_fwd_a_nxt;
            r_fwd_b <= w_fwd_b_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (PCSrc) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    // The WB entry is pure history: it must always equal what MEM held one
    // cycle earlier, whatever the stall/flush activity.
    a_wb_follows_mem: assert property (
        @(posedge Clk) disable iff (!Rst_n) r_s_wb == $past(r_s_mem)
    );

    // Bubbles and invalid slots never carry write or load intent.
    a_ex_clean: assert property (
        @(posedge Clk) disable iff (!Rst_n) (!r_s_ex.vld) |-> (!r_s_ex.rw && !r_s_ex.mr)
    );

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign PC_Write    = ~w_stall;
    assign IFID_Write  = ~w_stall;
    assign Flush_IFID  = PCSrc;
    assign Flush_IDEX  = PCSrc | w_stall;
    assign Flush_EXMEM = PCSrc;
    assign FwdA        = r_fwd_a;
    assign FwdB        = r_fwd_b;
    assign StallCnt    = r_stall_cnt;
    assign FlushCnt    = r_flush_cnt;

endmodule
